// File: rtl/sharpen_pkg.sv
// Shared types for the sharpen frame controller: FSM state encoding, the
// sharpen configuration record and its reset default.
package sharpen_pkg;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FRAME = 2'd1,
        S_BLANK = 2'd2
    } state_e;

    typedef struct packed {
        logic       bypass;
        logic [3:0] gain;
        logic [7:0] thresh;
    } cfg_t;

    localparam cfg_t CfgRst = '{bypass: 1'b1, gain: 4'd0, thresh: 8'd0};

endpackage

// File: rtl/sync_edge_det.sv
// Rise/fall detector with one register stage; the edge outputs are valid in the
// cycle the input changes and are consumed by registered logic downstream.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

endmodule

// File: rtl/sharpen_frame_ctrl.sv
// Frame controller for the Sobel sharpen pipeline: geometry checking and
// frame-synchronous config shadowing. Optional watchdog: SHARPEN_FRAME_CTRL_WDOG_EN.
module sharpen_frame_ctrl
    import sharpen_pkg::*;
#(
    parameter int unsigned H_DISP      = 1280,
    parameter int unsigned V_DISP      = 720,
    parameter int unsigned CNT_W       = 11,
    parameter int unsigned WDOG_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_img_vsync,
    input  logic        pre_img_hsync,
    input  logic        pre_img_valid,
    input  logic        cfg_bypass,
    input  logic [3:0]  cfg_gain,
    input  logic [7:0]  cfg_thresh,
    input  logic        cfg_update,
    output logic        cfg_ack,
    output logic        act_bypass,
    output logic [3:0]  act_gain,
    output logic [7:0]  act_thresh,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        err_line,
    output logic        err_frame,
    output logic        busy
);

    localparam logic [CNT_W-1:0] HDisp = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] VLast = CNT_W'(V_DISP - 1);
    localparam logic [CNT_W-1:0] ColMax = '1;

    state_e           state_q;
    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] row_q;
    cfg_t             act_q;
    cfg_t             pend_cfg_q;
    logic             pend_q;
    cfg_t             cfg_req;

    logic vs_rise;
    logic valid_fall;
    logic unused_vs_fall;
    logic unused_valid_rise;

    assign cfg_req = '{bypass: cfg_bypass, gain: cfg_gain, thresh: cfg_thresh};

    sync_edge_det u_vsync_det (
        .clk  (clk),
        .rst  (rst),
        .din  (pre_img_vsync),
        .rise (vs_rise),
        .fall (unused_vs_fall)
    );

    sync_edge_det u_valid_det (
        .clk  (clk),
        .rst  (rst),
        .din  (pre_img_valid),
        .rise (unused_valid_rise),
        .fall (valid_fall)
    );

`ifdef SHARPEN_FRAME_CTRL_WDOG_EN
    localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WdogW-1:0] WdogMax = WdogW'(WDOG_CYCLES);
    localparam logic [WdogW-1:0] WdogFire = WdogW'(WDOG_CYCLES - 1);
    logic [WdogW-1:0] wdog_q;
`else
    localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT;
            col_q       <= '0;
            row_q       <= '0;
            act_q       <= CfgRst;
            pend_cfg_q  <= CfgRst;
            pend_q      <= 1'b0;
            frame_cnt   <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
            cfg_ack     <= 1'b0;
            busy        <= 1'b0;
`ifdef SHARPEN_FRAME_CTRL_WDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
            cfg_ack     <= 1'b0;

            // Apply first, then stage: a coincident update waits for the next frame.
            if (vs_rise && pend_q) begin
                act_q   <= pend_cfg_q;
                pend_q  <= 1'b0;
                cfg_ack <= 1'b1;
            end
            if (cfg_update) begin
                pend_cfg_q <= cfg_req;
                pend_q     <= 1'b1;
            end

            if (vs_rise) begin
                frame_start <= 1'b1;
                if (state_q == S_FRAME) begin
                    err_frame <= 1'b1;
                    // vsync arrived inside a partially transferred line
                    if (pre_img_hsync && col_q != '0) begin
                        err_line <= 1'b1;
                    end
                end
                state_q <= S_FRAME;
                busy    <= 1'b1;
                col_q   <= '0;
                row_q   <= '0;
            end else if (state_q == S_FRAME) begin
                if (pre_img_valid) begin
                    if (col_q != ColMax) begin
                        col_q <= col_q + CNT_W'(1);
                    end
                end else if (valid_fall) begin
                    if (col_q != HDisp) begin
                        err_line <= 1'b1;
                    end
                    col_q <= '0;
                    row_q <= row_q + CNT_W'(1);
                    if (row_q == VLast) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state_q    <= S_BLANK;
                        busy       <= 1'b0;
                    end
                end
            end

`ifdef SHARPEN_FRAME_CTRL_WDOG_EN
            if (vs_rise) begin
                wdog_q <= '0;
            end else if (wdog_q != WdogMax) begin
                wdog_q <= wdog_q + WdogW'(1);
                if (wdog_q == WdogFire) begin
                    state_q   <= S_WAIT;
                    busy      <= 1'b0;
                    err_frame <= 1'b1;
                end
            end
`endif
        end
    end

    assign act_bypass = act_q.bypass;
    assign act_gain   = act_q.gain;
    assign act_thresh = act_q.thresh;

endmodule

// File: tb/tb_sharpen_frame_ctrl.sv
// Scoreboard bench for sharpen_frame_ctrl with an 8x4 frame geometry.
module tb_sharpen_frame_ctrl;

    localparam logic [4:0] P_FS  = 5'b10000;
    localparam logic [4:0] P_FD  = 5'b01000;
    localparam logic [4:0] P_EL  = 5'b00100;
    localparam logic [4:0] P_EF  = 5'b00010;
    localparam logic [4:0] P_ACK = 5'b00001;
    localparam logic [12:0] ACT_DEF = {1'b1, 4'd0, 8'd0};

    typedef struct {
        int          cyc;
        logic [4:0]  pulses;
        logic [15:0] fcnt;
        logic [12:0] act;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        hsync = 1'b0;
    logic        valid = 1'b0;
    logic        c_bypass = 1'b0;
    logic [3:0]  c_gain = 4'd0;
    logic [7:0]  c_thresh = 8'd0;
    logic        c_update = 1'b0;
    logic        cfg_ack;
    logic        act_bypass;
    logic [3:0]  act_gain;
    logic [7:0]  act_thresh;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_line;
    logic        err_frame;
    logic        busy;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          last_vs = 0;
    logic [12:0] exp_act = ACT_DEF;
    ev_t         exp_q[$];
    ev_t         ev;
    logic [4:0]  mon_p;

    sharpen_frame_ctrl #(
        .H_DISP      (8),
        .V_DISP      (4),
        .CNT_W       (11),
        .WDOG_CYCLES (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pre_img_vsync (vsync),
        .pre_img_hsync (hsync),
        .pre_img_valid (valid),
        .cfg_bypass    (c_bypass),
        .cfg_gain      (c_gain),
        .cfg_thresh    (c_thresh),
        .cfg_update    (c_update),
        .cfg_ack       (cfg_ack),
        .act_bypass    (act_bypass),
        .act_gain      (act_gain),
        .act_thresh    (act_thresh),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .err_line      (err_line),
        .err_frame     (err_frame),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Monitor: every cycle with any pulse consumes one expected event.
    always @(negedge clk) begin
        mon_p = {frame_start, frame_done, err_line, err_frame, cfg_ack};
        if (mon_p != 5'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {27'd0, mon_p}, 32'd0);
            end else begin
                ev = exp_q.pop_front();
                check("pulse_set", {27'd0, mon_p}, {27'd0, ev.pulses});
                check("pulse_cycle", cyc, ev.cyc);
                check("pulse_frame_cnt", {16'd0, frame_cnt}, {16'd0, ev.fcnt});
                check("pulse_act", {19'd0, act_bypass, act_gain, act_thresh}, {19'd0, ev.act});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic [4:0] p, input logic [15:0] fc);
        exp_q.push_back('{cyc: at, pulses: p, fcnt: fc, act: exp_act});
    endtask

    task automatic set_cfg(input logic [12:0] v);
        {c_bypass, c_gain, c_thresh} = v;
    endtask

    task automatic cfg_pulse(input logic [12:0] v);
        set_cfg(v);
        c_update = 1'b1;
        tick();
        c_update = 1'b0;
    endtask

    // Vsync rise; act_new/extra/fc are the hand-computed frame_start expectations.
    task automatic frame_begin(input logic [12:0] act_new, input logic [4:0] extra,
                               input logic [15:0] fc, input logic upd,
                               input logic [12:0] upd_val);
        vsync = 1'b1;
        if (upd) begin
            set_cfg(upd_val);
            c_update = 1'b1;
        end
        exp_act = act_new;
        push(cyc + 1, P_FS | extra, fc);
        last_vs = cyc + 1;
        tick();
        c_update = 1'b0;
        tick();
        vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic line(input int npix, input logic [4:0] p, input logic [15:0] fc);
        hsync = 1'b1;
        tick();
        valid = 1'b1;
        repeat (npix) tick();
        valid = 1'b0;
        if (p != 5'b0) push(cyc + 1, p, fc);
        hsync = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        check("rst_act", {19'd0, act_bypass, act_gain, act_thresh}, {19'd0, ACT_DEF});
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulses", {27'd0, frame_start, frame_done, err_line, err_frame, cfg_ack},
              32'd0);
        rst = 1'b0;
        tick();

        // Frame 1: clean.
        frame_begin(ACT_DEF, 5'b0, 16'd0, 1'b0, 13'd0);
        check("busy_in_frame1", {31'd0, busy}, 32'd1);
        repeat (3) line(8, 5'b0, 16'd0);
        line(8, P_FD, 16'd1);
        check("busy_blank1", {31'd0, busy}, 32'd0);

        // Frame 2: clean, config request mid-frame must not take effect yet.
        frame_begin(ACT_DEF, 5'b0, 16'd1, 1'b0, 13'd0);
        line(8, 5'b0, 16'd1);
        cfg_pulse({1'b0, 4'd3, 8'd40});
        check("act_held_mid", {19'd0, act_bypass, act_gain, act_thresh}, {19'd0, ACT_DEF});
        repeat (2) line(8, 5'b0, 16'd1);
        line(8, P_FD, 16'd2);
        check("act_held_blank", {19'd0, act_bypass, act_gain, act_thresh}, {19'd0, ACT_DEF});
        check("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);
        check("busy_blank2", {31'd0, busy}, 32'd0);

        // Frame 3: pending config applied with ack; short line in row 2.
        frame_begin({1'b0, 4'd3, 8'd40}, P_ACK, 16'd2, 1'b0, 13'd0);
        check("act_gain_3", {28'd0, act_gain}, 32'd3);
        check("act_thresh_40", {24'd0, act_thresh}, 32'd40);
        line(8, 5'b0, 16'd2);
        line(8, 5'b0, 16'd2);
        line(7, P_EL, 16'd2);
        line(8, P_FD, 16'd3);

        // Frame 4: three lines, two updates (last wins), then vsync with a new update.
        frame_begin({1'b0, 4'd3, 8'd40}, 5'b0, 16'd3, 1'b0, 13'd0);
        line(8, 5'b0, 16'd3);
        cfg_pulse({1'b1, 4'd9, 8'd9});
        line(8, 5'b0, 16'd3);
        cfg_pulse({1'b1, 4'd5, 8'd100});
        line(8, 5'b0, 16'd3);
        frame_begin({1'b1, 4'd5, 8'd100}, P_EF | P_ACK, 16'd3, 1'b1, {1'b0, 4'd7, 8'd200});
        check("act_gain_5", {28'd0, act_gain}, 32'd5);
        check("busy_restart", {31'd0, busy}, 32'd1);

        // Frame 5: restarted frame counts rows from zero.
        repeat (3) line(8, 5'b0, 16'd3);
        line(8, P_FD, 16'd4);

        // Frame 6: coincident update applied now; reset mid-line.
        frame_begin({1'b0, 4'd7, 8'd200}, P_ACK, 16'd4, 1'b0, 13'd0);
        check("act_thresh_200", {24'd0, act_thresh}, 32'd200);
        line(8, 5'b0, 16'd4);
        hsync = 1'b1;
        tick();
        valid = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid = 1'b0;
        hsync = 1'b0;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_act", {19'd0, act_bypass, act_gain, act_thresh}, {19'd0, ACT_DEF});
        check("rstmid_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        exp_act = ACT_DEF;
        repeat (3) tick();

        // Frame 7: recovery after reset.
        frame_begin(ACT_DEF, 5'b0, 16'd0, 1'b0, 13'd0);
        check("busy_in_frame7", {31'd0, busy}, 32'd1);
        repeat (3) line(8, 5'b0, 16'd0);
        line(8, P_FD, 16'd1);

`ifdef SHARPEN_FRAME_CTRL_WDOG_EN
        push(last_vs + 100, P_EF, 16'd1);
        while (cyc < last_vs + 130) tick();
        check("wdog_busy", {31'd0, busy}, 32'd0);
`endif

        repeat (5) tick();
        check("events_pending", exp_q.size(), 32'd0);
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front();
            $display("FAIL missing_event: pulses %b never seen, required at cycle %0d",
                     ev.pulses, ev.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
